// File: rtl/gbt_tx_frame_builder.sv
// Packs 64-bit status words into 84-bit GBT frames: SOP/DATA/TRAILER packets with rolling sequence and XOR checksum.
// One registered frame per clock, idle frames when no packet; HOLD frames cover input underrun, ABORT on link loss.
module gbt_tx_frame_builder #(
  parameter int PKT_FRAMES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk_ik,
  input  logic             rst_irn,
  input  logic             enable_i,
  input  logic [63:0]      data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [83:0]      frame_o,
  output logic             sop_o,
  output logic             pkt_done_o,
  output logic             pkt_abort_o,
  output logic [CNT_W-1:0] underrun_cnt_o,
  output logic [CNT_W-1:0] abort_cnt_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_TRAILER = 2'd2;

  localparam logic [7:0] HDR_IDLE    = 8'h00;
  localparam logic [7:0] HDR_SOP     = 8'hA5;
  localparam logic [7:0] HDR_DATA    = 8'h5A;
  localparam logic [7:0] HDR_HOLD    = 8'h3C;
  localparam logic [7:0] HDR_TRAILER = 8'hC3;
  localparam logic [7:0] HDR_ABORT   = 8'hFF;

  localparam logic [7:0] PKT_LEN = 8'(PKT_FRAMES);

  logic [1:0]       state_q, state_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [63:0]      chk_q, chk_d;
  logic [CNT_W-1:0] und_q, und_d;
  logic [CNT_W-1:0] abt_q, abt_d;
  logic [83:0]      frame_q, frame_d;
  logic             sop_q, sop_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic             accept;
  logic [7:0]       hdr;
  logic [7:0]       fseq;
  logic [63:0]      pay;

  assign ready_o = enable_i & rst_irn & (state_q != ST_TRAILER);
  assign accept  = valid_i & ready_o;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    und_d   = und_q;
    abt_d   = abt_q;
    hdr     = HDR_IDLE;
    fseq    = 8'h00;
    pay     = 64'h0;
    sop_d   = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hdr     = HDR_SOP;
          fseq    = seq_q;
          seq_d   = seq_q + 8'd1;
          pay     = data_i;
          chk_d   = data_i;
          cnt_d   = 8'd1;
          sop_d   = 1'b1;
          state_d = (PKT_FRAMES == 1) ? ST_TRAILER : ST_DATA;
        end
      end
      ST_DATA: begin
        // Link loss wins over any data or hold decision.
        if (!enable_i) begin
          hdr     = HDR_ABORT;
          abort_d = 1'b1;
          cnt_d   = 8'd0;
          chk_d   = 64'h0;
          state_d = ST_IDLE;
          if (abt_q != {CNT_W{1'b1}}) abt_d = abt_q + 1'b1;
        end else if (accept) begin
          hdr   = HDR_DATA;
          fseq  = seq_q;
          seq_d = seq_q + 8'd1;
          pay   = data_i;
          chk_d = chk_q ^ data_i;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == PKT_LEN) state_d = ST_TRAILER;
        end else begin
          hdr = HDR_HOLD;
          if (und_q != {CNT_W{1'b1}}) und_d = und_q + 1'b1;
        end
      end
      ST_TRAILER: begin
        if (enable_i) begin
          hdr    = HDR_TRAILER;
          fseq   = seq_q;
          seq_d  = seq_q + 8'd1;
          pay    = chk_q;
          done_d = 1'b1;
        end else begin
          hdr     = HDR_ABORT;
          abort_d = 1'b1;
          if (abt_q != {CNT_W{1'b1}}) abt_d = abt_q + 1'b1;
        end
        cnt_d   = 8'd0;
        chk_d   = 64'h0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    frame_d = {4'hF, hdr, fseq, pay};
  end

  always_ff @(posedge clk_ik or negedge rst_irn) begin
    if (!rst_irn) begin
      state_q <= ST_IDLE;
      seq_q   <= 8'h00;
      cnt_q   <= 8'h00;
      chk_q   <= 64'h0;
      und_q   <= '0;
      abt_q   <= '0;
      frame_q <= {4'hF, 80'h0};
      sop_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      und_q   <= und_d;
      abt_q   <= abt_d;
      frame_q <= frame_d;
      sop_q   <= sop_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign frame_o        = frame_q;
  assign sop_o          = sop_q;
  assign pkt_done_o     = done_q;
  assign pkt_abort_o    = abort_q;
  assign underrun_cnt_o = und_q;
  assign abort_cnt_o    = abt_q;

endmodule

// File: tb/tb_gbt_tx_frame_builder.sv
// Randomized and directed bench for gbt_tx_frame_builder against a packet-level reference model.
module tb_gbt_tx_frame_builder;
  localparam int P = 4;

  logic        clk, rst_n, enable_i, valid_i;
  logic [63:0] data_i;
  logic        rdy, sop, done, abt, rdy2, sop2, done2, abt2;
  logic [83:0] frame, frame2;
  logic [15:0] und, abc;
  logic [1:0]  und2, abc2;

  gbt_tx_frame_builder #(.PKT_FRAMES(P), .CNT_W(16)) dut (
    .clk_ik(clk), .rst_irn(rst_n), .enable_i(enable_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy), .frame_o(frame), .sop_o(sop), .pkt_done_o(done), .pkt_abort_o(abt),
    .underrun_cnt_o(und), .abort_cnt_o(abc));

  gbt_tx_frame_builder #(.PKT_FRAMES(P), .CNT_W(2)) dut2 (
    .clk_ik(clk), .rst_irn(rst_n), .enable_i(enable_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(rdy2), .frame_o(frame2), .sop_o(sop2), .pkt_done_o(done2), .pkt_abort_o(abt2),
    .underrun_cnt_o(und2), .abort_cnt_o(abc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the words of the open packet, whether a trailer is owed, and frame/event tallies.
  logic [63:0] m_words[$];
  bit          m_trl;
  int          m_num, m_und, m_abt;

  logic [83:0] exp_frame;
  logic [2:0]  exp_fl;
  logic        exp_rdy, obs_rdy;

  function automatic logic [83:0] mk(input logic [7:0] h, input logic [7:0] s, input logic [63:0] p);
    return {4'hF, h, s, p};
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_trl = 0;
    m_num = 0;
    m_und = 0;
    m_abt = 0;
  endtask

  // Drives one cycle (called 1 time unit after a rising edge) and predicts the frame that edge produces.
  task automatic step(input logic en, input logic vld, input logic [63:0] d);
    logic [63:0] x;
    enable_i = en; valid_i = vld; data_i = d;
    #2 obs_rdy = rdy;
    exp_rdy = en && !m_trl;
    exp_fl  = 3'b000;
    if (m_trl) begin
      if (en) begin
        x = 64'h0;
        foreach (m_words[i]) x ^= m_words[i];
        exp_frame = mk(8'hC3, 8'(m_num), x);
        m_num++;
        exp_fl = 3'b010;
      end else begin
        exp_frame = mk(8'hFF, 8'h00, 64'h0);
        m_abt++;
        exp_fl = 3'b001;
      end
      m_trl = 0;
      m_words.delete();
    end else if (m_words.size() == 0) begin
      if (en && vld) begin
        exp_frame = mk(8'hA5, 8'(m_num), d);
        m_num++;
        m_words.push_back(d);
        exp_fl = 3'b100;
        if (P == 1) m_trl = 1;
      end else begin
        exp_frame = mk(8'h00, 8'h00, 64'h0);
      end
    end else if (!en) begin
      exp_frame = mk(8'hFF, 8'h00, 64'h0);
      m_abt++;
      exp_fl = 3'b001;
      m_words.delete();
    end else if (vld) begin
      exp_frame = mk(8'h5A, 8'(m_num), d);
      m_num++;
      m_words.push_back(d);
      if (m_words.size() == P) m_trl = 1;
    end else begin
      exp_frame = mk(8'h3C, 8'h00, 64'h0);
      m_und++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable_i = 1'b1; valid_i = 1'b0; data_i = 64'h0;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    n_checks++;
    if ({frame, sop, done, abt} !== {4'hF, 80'h0, 3'b000})
      $display("FAIL reset_frame: got %h/%b%b%b want %h/000", frame, sop, done, abt, {4'hF, 80'h0});
    else n_pass++;
    n_checks++;
    if ({rdy, rdy2} !== 2'b00) $display("FAIL reset_ready: got %b%b want 00", rdy, rdy2);
    else n_pass++;
    n_checks++;
    if ({und, abc, und2, abc2} !== 36'h0)
      $display("FAIL reset_counters: got %h %h %h %h want 0", und, abc, und2, abc2);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [83:0] tbl[6];
    logic [2:0]  fl[6];
    tbl[0] = mk(8'hA5, 8'd0, 64'd1); fl[0] = 3'b100;
    tbl[1] = mk(8'h5A, 8'd1, 64'd2); fl[1] = 3'b000;
    tbl[2] = mk(8'h5A, 8'd2, 64'd3); fl[2] = 3'b000;
    tbl[3] = mk(8'h5A, 8'd3, 64'd4); fl[3] = 3'b000;
    tbl[4] = mk(8'hC3, 8'd4, 64'd4); fl[4] = 3'b010;
    tbl[5] = mk(8'h00, 8'd0, 64'd0); fl[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i < 4, 64'(i + 1));
      n_checks++;
      if ({frame, sop, done, abt} !== {tbl[i], fl[i]})
        $display("FAIL single_frame%0d: got %h/%b%b%b want %h/%b", i, frame, sop, done, abt, tbl[i], fl[i]);
      else n_pass++;
      n_checks++;
      if (obs_rdy !== (i != 4)) $display("FAIL single_ready%0d: got %b want %b", i, obs_rdy, i != 4);
      else n_pass++;
    end
  endtask

  task automatic test_underrun();
    logic [1:0] pat[10];
    pat = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 10; i++) begin
      step(pat[i][1], pat[i][0], {$urandom, $urandom});
      n_checks++;
      if ({frame, sop, done, abt} !== {exp_frame, exp_fl})
        $display("FAIL underrun_frame%0d: got %h/%b%b%b want %h/%b", i, frame, sop, done, abt, exp_frame, exp_fl);
      else n_pass++;
    end
    n_checks++;
    if (und !== 16'd3 || und2 !== 2'd3) $display("FAIL underrun_cnt: got %0d/%0d want 3/3", und, und2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 64'h1111);
    step(1'b1, 1'b1, 64'h2222);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({frame, sop, done, abt, rdy} !== {4'hF, 80'h0, 4'b0000})
      $display("FAIL midreset_async: got %h rdy=%b want %h rdy=0", frame, rdy, {4'hF, 80'h0});
    else n_pass++;
    n_checks++;
    if ({und, abc} !== 32'h0) $display("FAIL midreset_cnt: got und=%0d abc=%0d want 0/0", und, abc);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b1, 64'h55);
    n_checks++;
    if ({frame, sop} !== {mk(8'hA5, 8'h00, 64'h55), 1'b1})
      $display("FAIL midreset_sop: got %h sop=%b want %h sop=1", frame, sop, mk(8'hA5, 8'h00, 64'h55));
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'(i + 7));
    n_checks++;
    if ({frame, done} !== {exp_frame, 1'b1}) $display("FAIL midreset_trailer: got %h want %h", frame, exp_frame);
    else n_pass++;
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b1, 64'hABC);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 64'h0);
      n_checks++;
      if (und2 !== sat2(m_und) || und !== sat16(m_und))
        $display("FAIL saturation_hold%0d: got %0d/%0d want %0d/%0d", i, und2, und, sat2(m_und), sat16(m_und));
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {$urandom, $urandom});
    n_checks++;
    if (und2 !== 2'd3 || und !== 16'd5) $display("FAIL saturation_final: got %0d/%0d want 3/5", und2, und);
    else n_pass++;
  endtask

  task automatic test_abort();
    step(1'b1, 1'b1, 64'hDEAD);
    step(1'b0, 1'b1, 64'hBEEF);
    n_checks++;
    if ({frame, abt, abc} !== {mk(8'hFF, 8'h00, 64'h0), 1'b1, 16'd1})
      $display("FAIL abort_data: got %h abt=%b cnt=%0d want FF frame abt=1 cnt=1", frame, abt, abc);
    else n_pass++;
    step(1'b0, 1'b1, 64'h1234);
    n_checks++;
    if ({frame, obs_rdy, abc} !== {mk(8'h00, 8'h00, 64'h0), 1'b0, 16'd1})
      $display("FAIL abort_idle_disabled: got %h rdy=%b cnt=%0d", frame, obs_rdy, abc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, {$urandom, $urandom});
      n_checks++;
      if ({frame, sop, done, abt} !== {exp_frame, exp_fl})
        $display("FAIL abort_restart%0d: got %h want %h", i, frame, exp_frame);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {$urandom, $urandom});
    step(1'b0, 1'b0, 64'h0);
    n_checks++;
    if ({frame, abt, abc, abc2} !== {mk(8'hFF, 8'h00, 64'h0), 1'b1, 16'd2, 2'd2})
      $display("FAIL abort_trailer: got %h abt=%b cnt=%0d/%0d want FF abt=1 cnt=2/2", frame, abt, abc, abc2);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    bit saw_wrap = 0;
    int last = -1;
    for (int p = 0; p < 52; p++) begin
      for (int i = 0; i < P + 1; i++) begin
        step(1'b1, 1'b1, {$urandom, $urandom});
        if ({frame, sop, done, abt} !== {exp_frame, exp_fl}) begin
          if (bad < 4) $display("FAIL wrap_frame p%0d i%0d: got %h want %h", p, i, frame, exp_frame);
          bad++;
        end
        if (frame[79:72] inside {8'hA5, 8'h5A, 8'hC3}) begin
          if (last == 255 && frame[71:64] == 8'h00) saw_wrap = 1;
          last = int'(frame[71:64]);
        end
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL wrap_frames: got %0d bad frames want 0", bad);
    else n_pass++;
    n_checks++;
    if (saw_wrap !== 1'b1) $display("FAIL wrap_seen: got %b want 1", saw_wrap);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, {$urandom, $urandom});
      if ({frame, sop, done, abt, obs_rdy} !== {exp_frame, exp_fl, exp_rdy} ||
          {frame2, sop2, done2, abt2} !== {exp_frame, exp_fl} ||
          und !== sat16(m_und) || abc !== sat16(m_abt) ||
          und2 !== sat2(m_und) || abc2 !== sat2(m_abt)) begin
        if (bad < 4)
          $display("FAIL random_cycle%0d: got %h rdy=%b und=%0d abc=%0d want %h rdy=%b und=%0d abc=%0d",
                   c, frame, obs_rdy, und, abc, exp_frame, exp_rdy, m_und, m_abt);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL random: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_reset_mid();
    test_saturation();
    test_abort();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
